// File: rtl/ram_bus_if.sv
// Memory-side bus interface: MAR, 2**AW x DW synchronous RAM and a read/write handshake FSM.
// Optional build macro MAR_AUTOINC_EN: MAR post-increments when a completed access returns to IDLE.
module ram_bus_if #(
  parameter int AW = 8,
  parameter int DW = 8
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic [AW-1:0] ABUS,
  input  logic [DW-1:0] DIN,
  input  logic          LMAR,
  input  logic          RD,
  input  logic          WR,
  output logic [DW-1:0] DBUS,
  output logic          DBUS_OE,
  output logic          RDY,
  output logic [AW-1:0] MAR
);

  // Handshake: a request (RD or WR, active low) is accepted only in IDLE and only if
  // exactly one is low. RDY acknowledges it and stays high for as long as the requester
  // holds the request low; the requester releases it once RDY is seen, and the access
  // completes (returns to IDLE) on the edge where the release is sampled.
  typedef enum logic [1:0] {IDLE, RD1, RDV, WR1} state_t;

  state_t        state, state_nxt;
  logic [DW-1:0] mem [0:(2**AW)-1];
  logic [DW-1:0] rdata;
  logic [AW-1:0] mar_nxt;
  logic [DW-1:0] dbus_nxt;
  logic          oe_nxt;
  logic          rdy_nxt;
  logic          mem_we;
  logic          rdata_ld;

  always_comb begin
    state_nxt = state;
    mar_nxt   = MAR;
    dbus_nxt  = '0;
    oe_nxt    = 1'b0;
    rdy_nxt   = 1'b0;
    mem_we    = 1'b0;
    rdata_ld  = 1'b0;
    case (state)
      IDLE: begin
        if (!LMAR) mar_nxt = ABUS;
        if (!RD && WR) begin
          state_nxt = RD1;
        end else if (!WR && RD) begin
          mem_we    = 1'b1;
          rdy_nxt   = 1'b1;
          state_nxt = WR1;
        end
      end
      RD1: begin
        rdata_ld  = 1'b1;
        state_nxt = RDV;
      end
      RDV: begin
        if (!RD) begin
          dbus_nxt = rdata;
          oe_nxt   = 1'b1;
          rdy_nxt  = 1'b1;
        end else begin
          state_nxt = IDLE;
`ifdef MAR_AUTOINC_EN
          mar_nxt = MAR + AW'(1);
`endif
        end
      end
      WR1: begin
        // The write already happened on entry; holding WR low only holds the acknowledge.
        if (!WR) begin
          rdy_nxt = 1'b1;
        end else begin
          state_nxt = IDLE;
`ifdef MAR_AUTOINC_EN
          mar_nxt = MAR + AW'(1);
`endif
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state   <= IDLE;
      MAR     <= '0;
      DBUS    <= '0;
      DBUS_OE <= 1'b0;
      RDY     <= 1'b0;
      rdata   <= '0;
    end else begin
      state   <= state_nxt;
      MAR     <= mar_nxt;
      DBUS    <= dbus_nxt;
      DBUS_OE <= oe_nxt;
      RDY     <= rdy_nxt;
      if (rdata_ld) rdata <= mem[MAR];
    end
  end

  // RAM has no reset; a write request coinciding with reset is dropped.
  always_ff @(posedge CLK) begin
    if (mem_we && !RST) mem[MAR] <= DIN;
  end

endmodule

// File: tb/tb_ram_bus_if.sv
// Directed self-checking bench for ram_bus_if; expectations follow MAR_AUTOINC_EN when defined.
module tb_ram_bus_if;

  logic       clk;
  logic       rst;
  logic [7:0] abus;
  logic [7:0] din;
  logic       lmar;
  logic       rd;
  logic       wr;
  logic [7:0] dbus;
  logic       dbus_oe;
  logic       rdy;
  logic [7:0] mar;

  int errors = 0;
  int checks = 0;

`ifdef MAR_AUTOINC_EN
  localparam bit AUTOINC = 1'b1;
`else
  localparam bit AUTOINC = 1'b0;
`endif

  ram_bus_if #(.AW(8), .DW(8)) dut (
    .CLK(clk), .RST(rst), .ABUS(abus), .DIN(din), .LMAR(lmar), .RD(rd), .WR(wr),
    .DBUS(dbus), .DBUS_OE(dbus_oe), .RDY(rdy), .MAR(mar)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // driver tasks
  task automatic load_mar(input logic [7:0] a);
    abus = a;
    lmar = 1'b0;
    tick();
    lmar = 1'b1;
  endtask

  task automatic write_at(input logic [7:0] a, input logic [7:0] d);
    load_mar(a);
    din = d;
    wr  = 1'b0;
    tick();
    wr  = 1'b1;
    tick();
  endtask

  task automatic read_at(input string tag, input logic [7:0] a, input logic [7:0] exp);
    load_mar(a);
    rd = 1'b0;
    tick();
    tick();
    tick();
    chk(tag, dbus, exp);
    chk({tag, "_oe"}, dbus_oe, 1'b1);
    rd = 1'b1;
    tick();
  endtask

  initial begin
    rst = 1'b1; abus = '0; din = '0; lmar = 1'b1; rd = 1'b1; wr = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    chk("rst_mar", mar, 8'h00);
    chk("rst_dbus", dbus, 8'h00);
    chk("rst_oe", dbus_oe, 1'b0);
    chk("rst_rdy", rdy, 1'b0);

    // write 0x76 to 0x07
    load_mar(8'h07);
    chk("lmar_07", mar, 8'h07);
    din = 8'h76;
    wr  = 1'b0;
    tick();
    chk("wr_rdy", rdy, 1'b1);
    tick();
    chk("wr_rdy_hold", rdy, 1'b1);
    wr = 1'b1;
    tick();
    chk("wr_rdy_drop", rdy, 1'b0);
    chk("wr_mar_after", mar, AUTOINC ? 8'h08 : 8'h07);

    // read back with latency checks
    load_mar(8'h07);
    rd = 1'b0;
    tick();
    chk("rd_n_oe", dbus_oe, 1'b0);
    tick();
    chk("rd_n1_rdy", rdy, 1'b0);
    chk("rd_n1_dbus", dbus, 8'h00);
    tick();
    chk("rd_dbus", dbus, 8'h76);
    chk("rd_oe", dbus_oe, 1'b1);
    chk("rd_rdy", rdy, 1'b1);

    // LMAR ignored while busy
    abus = 8'hC0;
    lmar = 1'b0;
    tick();
    lmar = 1'b1;
    chk("busy_mar", mar, 8'h07);
    chk("busy_dbus", dbus, 8'h76);
    rd = 1'b1;
    tick();
    chk("rel_dbus", dbus, 8'h00);
    chk("rel_oe", dbus_oe, 1'b0);
    chk("rel_rdy", rdy, 1'b0);
    chk("rel_mar", mar, AUTOINC ? 8'h08 : 8'h07);

    // simultaneous RD/WR ignored
    write_at(8'h05, 8'h3A);
    load_mar(8'h05);
    din = 8'hEE;
    rd  = 1'b0;
    wr  = 1'b0;
    tick();
    chk("both_rdy", rdy, 1'b0);
    chk("both_oe", dbus_oe, 1'b0);
    tick();
    chk("both_rdy2", rdy, 1'b0);
    chk("both_mar", mar, 8'h05);
    rd = 1'b1;
    wr = 1'b1;
    tick();
    read_at("both_mem", 8'h05, 8'h3A);

    // reset coinciding with a write request
    write_at(8'h10, 8'h21);
    load_mar(8'h10);
    din = 8'h80;
    wr  = 1'b0;
    rst = 1'b1;
    tick();
    chk("rstwr_rdy", rdy, 1'b0);
    chk("rstwr_mar", mar, 8'h00);
    rst = 1'b0;
    wr  = 1'b1;
    tick();
    read_at("rstwr_mem", 8'h10, 8'h21);

    // reset aborting a read in RDV
    load_mar(8'h07);
    rd = 1'b0;
    tick();
    tick();
    tick();
    chk("rstrd_pre_oe", dbus_oe, 1'b1);
    rst = 1'b1;
    tick();
    chk("rstrd_oe", dbus_oe, 1'b0);
    chk("rstrd_dbus", dbus, 8'h00);
    chk("rstrd_rdy", rdy, 1'b0);
    rst = 1'b0;
    rd  = 1'b1;
    tick();
    // RD was released, so the FSM must be idle and accept a fresh read
    read_at("rstrd_again", 8'h07, 8'h76);

    // MAR at top of range
    load_mar(8'hFF);
    din = 8'h55;
    wr  = 1'b0;
    tick();
    wr  = 1'b1;
    tick();
    chk("wrap_mar", mar, AUTOINC ? 8'h00 : 8'hFF);
    read_at("wrap_mem", 8'hFF, 8'h55);

    // final report
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
